wb_lsu_master: RTL and testbench

WB_LSU_MASTER -- requirements
Module: wb_lsu_master

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_lsu_master_if.sv | 36 +++
 rtl/wb_addr_decode.sv | 18 +
 rtl/wb_lsu_master.sv | 145 ++++++++++++++
 tb/tb_wb_lsu_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared FSM encoding, window defaults and timeout default for the LSU Wishbone master
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [31:0] RSA_BASE_DEF       = 32'h4000_0000;
    localparam logic [31:0] RSA_MASK_DEF       = 32'hFFFF_FFC0;
    localparam logic [31:0] MEM_BASE_DEF       = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK_DEF       = 32'hFFFF_0000;
    localparam int          TIMEOUT_CYCLES_DEF = 16;

    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_lsu_master_if.sv
// rtl/wb_lsu_master_if.sv - CPU LSU handshake and Wishbone bus signals of the LSU master
interface wb_lsu_master_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        rsa_en;
    logic        mem_en;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    // master: the LSU bridge itself; slave: the CPU LSU plus the bus fabric around it
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_dat_i, wb_ack_i,
        output cpu_ready, cpu_done, cpu_rdata, cpu_err,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, rsa_en, mem_en
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_dat_i, wb_ack_i,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_err,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, rsa_en, mem_en
    );

endinterface

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational window decode, RSA window wins on overlap
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter logic [31:0] RSA_BASE = RSA_BASE_DEF,
    parameter logic [31:0] RSA_MASK = RSA_MASK_DEF,
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [31:0] MEM_MASK = MEM_MASK_DEF
) (
    input  logic [31:0] addr_i,
    output logic        rsa_hit_o,
    output logic        mem_hit_o
);

    assign rsa_hit_o = win_hit(addr_i, RSA_BASE, RSA_MASK);
    assign mem_hit_o = !rsa_hit_o && win_hit(addr_i, MEM_BASE, MEM_MASK);

endmodule

// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - RV32I LSU to Wishbone master; WB_TIMEOUT_EN adds an ack timeout abort
module wb_lsu_master
    import wb_pkg::*;
#(
    parameter logic [31:0] RSA_BASE       = RSA_BASE_DEF,
    parameter logic [31:0] RSA_MASK       = RSA_MASK_DEF,
    parameter logic [31:0] MEM_BASE       = MEM_BASE_DEF,
    parameter logic [31:0] MEM_MASK       = MEM_MASK_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic             clk,
    input logic             rst,
    wb_lsu_master_if.master lsu
);

    lsu_state_t  state_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic        stb_q;
    logic        rsa_en_q;
    logic        mem_en_q;
    logic        done_q;
    logic        err_q;
    logic        rsa_hit;
    logic        mem_hit;
    logic        tmo_hit;

    wb_addr_decode #(
        .RSA_BASE (RSA_BASE),
        .RSA_MASK (RSA_MASK),
        .MEM_BASE (MEM_BASE),
        .MEM_MASK (MEM_MASK)
    ) u_decode (
        .addr_i    (lsu.cpu_addr),
        .rsa_hit_o (rsa_hit),
        .mem_hit_o (mem_hit)
    );

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_lsu_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Counts completed BUS cycles; the abort fires on the edge ending cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_BUS) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_BUS) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            stb_q    <= 1'b0;
            rsa_en_q <= 1'b0;
            mem_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu.cpu_req) begin
                        if (rsa_hit || mem_hit) begin
                            adr_q    <= lsu.cpu_addr;
                            dat_q    <= lsu.cpu_wdata;
                            we_q     <= lsu.cpu_we;
                            stb_q    <= 1'b1;
                            rsa_en_q <= rsa_hit;
                            mem_en_q <= mem_hit;
                            state_q  <= ST_BUS;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_BUS: begin
                    // Strobe and select drop on the ack edge so a re-acking slave cannot retrigger.
                    if (lsu.wb_ack_i) begin
                        stb_q    <= 1'b0;
                        we_q     <= 1'b0;
                        rsa_en_q <= 1'b0;
                        mem_en_q <= 1'b0;
                        rdata_q  <= we_q ? 32'h0 : lsu.wb_dat_i;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_RESP;
                    end else if (tmo_hit) begin
                        stb_q    <= 1'b0;
                        we_q     <= 1'b0;
                        rsa_en_q <= 1'b0;
                        mem_en_q <= 1'b0;
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // A decode error arrives here without done set and spends one extra cycle.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lsu.cpu_ready = (state_q == ST_IDLE);
    assign lsu.cpu_done  = done_q;
    assign lsu.cpu_rdata = rdata_q;
    assign lsu.cpu_err   = err_q;
    assign lsu.wb_adr_o  = adr_q;
    assign lsu.wb_dat_o  = dat_q;
    assign lsu.wb_we_o   = we_q;
    assign lsu.wb_cyc_o  = stb_q;
    assign lsu.wb_stb_o  = stb_q;
    assign lsu.rsa_en    = rsa_en_q;
    assign lsu.mem_en    = mem_en_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - scoreboard bench for wb_lsu_master with a registered-ack slave model
module tb_wb_lsu_master;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_lsu_master_if lsu_if ();

    wb_lsu_master dut (
        .clk (clk),
        .rst (rst),
        .lsu (lsu_if)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_issued = 0;
    int          done_cnt = 0;
    logic        slave_ack_en;
    logic        stray_ack;
    logic        ack_q;
    logic [31:0] rd_q;
    logic [31:0] rsa_regs [16];
    logic [31:0] mem_words [256];
    logic [31:0] ref_mem [256];

    // Slave with one wait state: acks the cycle after it sees a strobe, then never twice in a row.
    always @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            rd_q  <= 32'h0;
        end else begin
            ack_q <= slave_ack_en && lsu_if.wb_stb_o && !ack_q;
            if (slave_ack_en && lsu_if.wb_stb_o && !ack_q) begin
                if (lsu_if.rsa_en) begin
                    if (lsu_if.wb_we_o) rsa_regs[lsu_if.wb_adr_o[5:2]] <= lsu_if.wb_dat_o;
                    else                rd_q <= rsa_regs[lsu_if.wb_adr_o[5:2]];
                end else if (lsu_if.mem_en) begin
                    if (lsu_if.wb_we_o) mem_words[lsu_if.wb_adr_o[9:2]] <= lsu_if.wb_dat_o;
                    else                rd_q <= mem_words[lsu_if.wb_adr_o[9:2]];
                end
            end
        end
    end

    assign lsu_if.wb_ack_i = ack_q | stray_ack;
    assign lsu_if.wb_dat_i = ack_q ? rd_q : (stray_ack ? 32'hDEAD_BEEF : 32'h0);

    always @(posedge clk) begin
        if (!rst && lsu_if.cpu_done === 1'b1) done_cnt++;
    end

    function automatic exp_t mk_exp(input logic err, input logic [31:0] rdata);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        return e;
    endfunction

    function automatic exp_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [102:0] all_outs();
        return {lsu_if.wb_stb_o, lsu_if.wb_cyc_o, lsu_if.wb_we_o, lsu_if.rsa_en, lsu_if.mem_en,
                lsu_if.cpu_done, lsu_if.cpu_err, lsu_if.wb_adr_o, lsu_if.wb_dat_o, lsu_if.cpu_rdata};
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        lsu_if.cpu_req   = 1'b1;
        lsu_if.cpu_we    = we;
        lsu_if.cpu_addr  = addr;
        lsu_if.cpu_wdata = wdata;
        exp_q.push_back(e);
        n_issued++;
        @(negedge clk);
        lsu_if.cpu_req = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic err, output logic [31:0] rdata,
                             output logic [1:0] sel, output logic stb_seen);
        lat      = 0;
        stb_seen = 1'b0;
        while (lsu_if.cpu_done !== 1'b1 && lat < 64) begin
            stb_seen = stb_seen | lsu_if.wb_stb_o;
            @(negedge clk);
            lat++;
        end
        err   = lsu_if.cpu_err;
        rdata = lsu_if.cpu_rdata;
        sel   = {lsu_if.rsa_en, lsu_if.mem_en};
        n_checks++;
        if (lsu_if.cpu_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_wait: cpu_done=%b after %0d cycles, required 1 within 64", lsu_if.cpu_done, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        lsu_if.cpu_req   = 1'b0;
        lsu_if.cpu_we    = 1'b0;
        lsu_if.cpu_addr  = 32'h0;
        lsu_if.cpu_wdata = 32'h0;
        slave_ack_en     = 1'b1;
        stray_ack        = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 103'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lsu_if.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", lsu_if.cpu_ready);
        end
    endtask

    task automatic test_rsa_store();
        logic [5:0] tab [4];
        logic [5:0] obs;
        exp_t       e;
        tab[0] = 6'b111100;
        tab[1] = 6'b111100;
        tab[2] = 6'b000001;
        tab[3] = 6'b000000;
        issue(1'b1, 32'h4000_0008, 32'h0000_0011, mk_exp(1'b0, 32'h0));
        for (int k = 0; k < 4; k++) begin
            obs = {lsu_if.wb_stb_o, lsu_if.wb_cyc_o, lsu_if.wb_we_o, lsu_if.rsa_en, lsu_if.mem_en, lsu_if.cpu_done};
            n_checks++;
            if (obs !== tab[k]) begin
                n_fail++;
                $display("FAIL store_seq[%0d]: {stb,cyc,we,rsa,mem,done} got %b required %b", k, obs, tab[k]);
            end
            if (k == 1) begin
                n_checks++;
                if ({lsu_if.wb_adr_o, lsu_if.wb_dat_o} !== {32'h4000_0008, 32'h0000_0011}) begin
                    n_fail++;
                    $display("FAIL store_adr_dat: got %h %h required 40000008 00000011", lsu_if.wb_adr_o, lsu_if.wb_dat_o);
                end
            end
            if (k == 2) begin
                e = pop_exp();
                n_checks++;
                if ({lsu_if.cpu_err, lsu_if.cpu_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL store_resp: got err=%b rdata=%h required err=%b rdata=%h",
                             lsu_if.cpu_err, lsu_if.cpu_rdata, e.err, e.rdata);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (rsa_regs[2] !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL store_slave_reg: got %h required 00000011", rsa_regs[2]);
        end
    endtask

    task automatic test_rsa_load();
        int          lat;
        logic        err;
        logic        stb_seen;
        logic [1:0]  sel;
        logic [31:0] rdata;
        exp_t        e;
        issue(1'b1, 32'h4000_001C, 32'hCAFE_0001, mk_exp(1'b0, 32'h0));
        wait_done(lat, err, rdata, sel, stb_seen);
        e = pop_exp();
        issue(1'b0, 32'h4000_001C, 32'h0, mk_exp(1'b0, 32'hCAFE_0001));
        wait_done(lat, err, rdata, sel, stb_seen);
        e = pop_exp();
        n_checks++;
        if ({err, rdata} !== e) begin
            n_fail++;
            $display("FAIL rsa_load_data: got err=%b rdata=%h required err=%b rdata=%h", err, rdata, e.err, e.rdata);
        end
        n_checks++;
        if ({lat, sel} !== {32'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL rsa_load_timing: got lat=%0d sel=%b required lat=2 sel=00", lat, sel);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] tab [4];
        int          lat;
        logic        err;
        logic        stb_seen;
        logic [1:0]  sel;
        logic [31:0] rdata;
        exp_t        e;
        tab[0] = 32'h8000_0000;
        tab[1] = 32'h0001_0000;
        tab[2] = 32'h4000_0040;
        tab[3] = 32'h3FFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            issue(i[0], tab[i], 32'h5555_AAAA, mk_exp(1'b1, 32'h0));
            wait_done(lat, err, rdata, sel, stb_seen);
            e = pop_exp();
            n_checks++;
            if ({err, rdata} !== e || lat != 1 || stb_seen !== 1'b0) begin
                n_fail++;
                $display("FAIL unmapped[%h]: got err=%b rdata=%h lat=%0d stb=%b required err=1 rdata=0 lat=1 stb=0",
                         tab[i], err, rdata, lat, stb_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int          lat;
        logic        err;
        logic        stb_seen;
        logic [1:0]  sel;
        logic [31:0] rdata;
        logic [31:0] d;
        exp_t        e;
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0004;
        addrs[2] = 32'h0000_FFFC;
        addrs[3] = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            ref_mem[addrs[i][9:2]] = d;
            issue(1'b1, addrs[i], d, mk_exp(1'b0, 32'h0));
            n_checks++;
            if ({lsu_if.rsa_en, lsu_if.mem_en} !== 2'b01) begin
                n_fail++;
                $display("FAIL mem_select[%h]: got %b required 01", addrs[i], {lsu_if.rsa_en, lsu_if.mem_en});
            end
            wait_done(lat, err, rdata, sel, stb_seen);
            e = pop_exp();
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], 32'h0, mk_exp(1'b0, ref_mem[addrs[i][9:2]]));
            wait_done(lat, err, rdata, sel, stb_seen);
            e = pop_exp();
            n_checks++;
            if ({err, rdata} !== e || lat != 2) begin
                n_fail++;
                $display("FAIL mem_load[%h]: got err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=2",
                         addrs[i], err, rdata, lat, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_ignored();
        int          lat;
        logic        err;
        logic        stb_seen;
        logic [1:0]  sel;
        logic [31:0] rdata;
        exp_t        e;
        issue(1'b1, 32'h0000_0014, 32'hA5A5_0F0F, mk_exp(1'b0, 32'h0));
        lsu_if.cpu_req  = 1'b1;
        lsu_if.cpu_we   = 1'b0;
        lsu_if.cpu_addr = 32'h8000_0000;
        @(negedge clk);
        lsu_if.cpu_req = 1'b0;
        n_checks++;
        if ({lsu_if.wb_adr_o, lsu_if.wb_we_o, lsu_if.wb_stb_o} !== {32'h0000_0014, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL req_in_bus: got adr=%h we=%b stb=%b required 00000014 1 1",
                     lsu_if.wb_adr_o, lsu_if.wb_we_o, lsu_if.wb_stb_o);
        end
        wait_done(lat, err, rdata, sel, stb_seen);
        e = pop_exp();
        n_checks++;
        if ({err, rdata} !== e) begin
            n_fail++;
            $display("FAIL ignored_resp: got err=%b rdata=%h required err=0 rdata=0", err, rdata);
        end
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        n_checks++;
        if ({lsu_if.cpu_ready, lsu_if.cpu_done, lsu_if.wb_stb_o, lsu_if.cpu_rdata} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL stray_ack: got ready=%b done=%b stb=%b rdata=%h required 1 0 0 0",
                     lsu_if.cpu_ready, lsu_if.cpu_done, lsu_if.wb_stb_o, lsu_if.cpu_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic        err;
        logic        stb_seen;
        logic [1:0]  sel;
        logic [31:0] rdata;
        exp_t        e;
        slave_ack_en = 1'b0;
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, mk_exp(1'b0, 32'h0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== 103'h0 || lsu_if.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got outs=%h ready=%b required 0 and 1", all_outs(), lsu_if.cpu_ready);
        end
        rst = 1'b0;
        void'(exp_q.pop_back());
        n_issued--;
        slave_ack_en = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h0000_0004, 32'h0, mk_exp(1'b0, ref_mem[1]));
        wait_done(lat, err, rdata, sel, stb_seen);
        e = pop_exp();
        n_checks++;
        if ({err, rdata} !== e || lat != 2) begin
            n_fail++;
            $display("FAIL after_reset_load: got err=%b rdata=%h lat=%0d required err=0 rdata=%h lat=2",
                     err, rdata, lat, e.rdata);
        end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        int   hi;
        exp_t e;
        slave_ack_en = 1'b0;
        issue(1'b0, 32'h0000_0008, 32'h0, mk_exp(1'b1, 32'h0));
        hi = 0;
        while (lsu_if.wb_stb_o === 1'b1 && hi < 64) begin
            hi++;
            @(negedge clk);
        end
        e = pop_exp();
        n_checks++;
        if (hi != 16 || lsu_if.cpu_done !== 1'b1 || {lsu_if.cpu_err, lsu_if.cpu_rdata} !== e) begin
            n_fail++;
            $display("FAIL timeout: got stb_cycles=%0d done=%b err=%b rdata=%h required 16 1 1 0",
                     hi, lsu_if.cpu_done, lsu_if.cpu_err, lsu_if.cpu_rdata);
        end
        @(negedge clk);
        slave_ack_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_rsa_store();
        test_rsa_load();
        test_unmapped();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != n_issued || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_count: got %0d dones, %0d pending required %0d dones, 0 pending",
                     done_cnt, exp_q.size(), n_issued);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
